uart_tx_feeder: RTL

Buffers bytes produced by the system side and feeds them one frame at a time to the UART transmitter control FSM in the TX clock domain. It holds a small synchronous FIFO and a hand-off FSM. The FSM issues a single-cycle `tx_data_valid` with stable `tx_p_data` whenever the transmitter is idle, then tracks `tx_busy` to know when the frame has finished. It sits directly upstream of the TX FSM/serializer and downstream of the register file/CDC stage.

---
 rtl/uart_tx_feeder_if.sv | 26 ++
 rtl/uart_tx_feeder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder_if.sv
// Bundles the write-side FIFO signals and the TX-FSM hand-off signals of uart_tx_feeder.
// Use the slave modport on the feeder and the master modport on its environment.
interface uart_tx_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic                    tx_busy;
    logic                    tx_data_valid;
    logic [DATA_WIDTH-1:0]   tx_p_data;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, overflow, tx_data_valid, tx_p_data
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, overflow, tx_data_valid, tx_p_data
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Small synchronous FIFO plus a hand-off FSM that feeds one byte at a time to the UART TX FSM.
// A request that is not answered by tx_busy within three cycles is re-issued with the same byte.
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    uart_tx_feeder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic                  full;
    logic                  empty;
    logic                  wr_accept;
    logic                  pop;

    state_t                state_reg;
    state_t                state_next;
    logic [1:0]            tmo_reg;
    logic [1:0]            tmo_next;
    logic                  valid_reg;
    logic                  valid_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  overflow_reg;

    // The extra pointer MSB separates a full ring from an empty one.
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign wr_accept = bus.wr_en && !full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            overflow_reg <= bus.wr_en && full;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg[AW-1:0]] <= bus.wr_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        valid_next = 1'b0;
        tmo_next   = tmo_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty && !bus.tx_busy) begin
                    pop        = 1'b1;
                    valid_next = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                tmo_next   = 2'd0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    tmo_next   = 2'd0;
                    state_next = WAIT_DONE;
                end else if (tmo_reg == 2'd2) begin
                    // Third quiet cycle: the TX FSM missed the request, so repeat it.
                    tmo_next   = 2'd0;
                    valid_next = 1'b1;
                    state_next = ISSUE;
                end else begin
                    tmo_next = tmo_reg + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                tmo_next   = 2'd0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            tmo_reg   <= 2'd0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            tmo_reg   <= tmo_next;
            valid_reg <= valid_next;
            if (pop) begin
                data_reg <= mem[rd_ptr_reg[AW-1:0]];
            end
        end
    end

    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.count         = wr_ptr_reg - rd_ptr_reg;
    assign bus.overflow      = overflow_reg;
    assign bus.tx_data_valid = valid_reg;
    assign bus.tx_p_data     = data_reg;

    a_valid_single: assert property (@(posedge clk) disable iff (!rstn)
        valid_reg |=> !valid_reg);
    a_data_stable: assert property (@(posedge clk) disable iff (!rstn)
        bus.tx_busy |-> $stable(data_reg));
endmodule
